// File: rtl/sdrxframe.sv
// sdrxframe: SD-card style DAT-line block receiver.
//
// Waits for a start bit on every active lane, assembles 1/4/8-bit samples
// into 32-bit words (first-received bits in the MSBs), runs an independent
// serial CRC per lane, checks the received per-lane CRCs and the end bit,
// then reports completion.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_cfg_width  bus width: 00 = 1 lane, 01 = 4 lanes, 1x = 8 lanes
//   i_en         arm / hold reception; dropping it aborts the frame
//   i_length     block length in bytes (multiple of 4, nonzero)
//   i_rx_strb    one DAT sample is valid this cycle
//   i_rx_data    DAT[7:0] sample, DAT0 on bit 0
//   M_VALID      received word valid (single-cycle pulse)
//   M_DATA       received word
//   M_LAST       qualifies the final word of the block
//   o_done       single-cycle pulse at frame completion
//   o_err        CRC or end-bit error, valid with o_done, held until re-arm
//   o_active     receiver is not idle
module sdrxframe #(
    parameter int              NCRC           = 16,
    parameter logic [NCRC-1:0] CRC_POLYNOMIAL = 16'h1021,
    parameter int              LGLEN          = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_cfg_width,
    input  logic             i_en,
    input  logic [LGLEN-1:0] i_length,
    input  logic             i_rx_strb,
    input  logic [7:0]       i_rx_data,
    output logic             M_VALID,
    output logic [31:0]      M_DATA,
    output logic             M_LAST,
    output logic             o_done,
    output logic             o_err,
    output logic             o_active
);

    // Bit counter covers both the per-word strobe count and the CRC strobes.
    localparam int CW = $clog2((NCRC > 32) ? NCRC : 32);
    localparam logic [LGLEN-3:0] WORD_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CRC,
        S_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        width_r;
    logic [LGLEN-3:0]  len_words;
    logic [LGLEN-3:0]  word_cnt;
    logic [CW-1:0]     bit_cnt;
    logic [31:0]       word_sr;
    logic [NCRC-1:0]   crc [8];
    logic              crc_err;

    logic [7:0]        lane_mask;
    logic [7:0]        lane_bits;
    logic [31:0]       word_next;
    logic [CW-1:0]     word_term;
    logic              word_end;
    logic              is_last;
    logic              crc_end;

    function automatic logic [NCRC-1:0] crc_step(input logic [NCRC-1:0] c, input logic b);
        crc_step = {c[NCRC-2:0], 1'b0} ^ ((c[NCRC-1] ^ b) ? CRC_POLYNOMIAL : '0);
    endfunction

    always_comb begin
        lane_mask = 8'hFF;
        word_next = {word_sr[23:0], i_rx_data};
        word_term = CW'(3);
        case (width_r)
            2'b00: begin
                lane_mask = 8'h01;
                word_next = {word_sr[30:0], i_rx_data[0]};
                word_term = CW'(31);
            end
            2'b01: begin
                lane_mask = 8'h0F;
                word_next = {word_sr[27:0], i_rx_data[3:0]};
                word_term = CW'(7);
            end
            default: ;
        endcase
        lane_bits = i_rx_data & lane_mask;
        word_end  = (bit_cnt == word_term);
        is_last   = (word_cnt == len_words - WORD_ONE);
        crc_end   = (bit_cnt == CW'(NCRC - 1));
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (i_en)
                state_nxt = S_START;
        end else if (!i_en) begin
            state_nxt = S_IDLE;
        end else if (i_rx_strb) begin
            case (state)
                S_START: if (lane_bits == 8'h00) state_nxt = S_DATA;
                S_DATA:  if (word_end && is_last) state_nxt = S_CRC;
                S_CRC:   if (crc_end) state_nxt = S_STOP;
                S_STOP:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    assign o_active = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            M_VALID   <= 1'b0;
            M_DATA    <= '0;
            M_LAST    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            width_r   <= '0;
            len_words <= '0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            word_sr   <= '0;
            crc_err   <= 1'b0;
            for (int unsigned n = 0; n < 8; n++)
                crc[n] <= '0;
        end else begin
            M_VALID <= 1'b0;
            M_LAST  <= 1'b0;
            o_done  <= 1'b0;
            if (state == S_IDLE) begin
                if (i_en) begin
                    width_r   <= i_cfg_width;
                    len_words <= i_length[LGLEN-1:2];
                    o_err     <= 1'b0;
                    word_cnt  <= '0;
                    bit_cnt   <= '0;
                    word_sr   <= '0;
                    crc_err   <= 1'b0;
                    for (int unsigned n = 0; n < 8; n++)
                        crc[n] <= '0;
                end
            end else if (i_en && i_rx_strb) begin
                // Gating on i_en here is what discards a word whose
                // completing strobe coincides with an abort.
                case (state)
                    S_DATA: begin
                        word_sr <= word_next;
                        for (int unsigned n = 0; n < 8; n++)
                            crc[n] <= crc_step(crc[n], i_rx_data[n]);
                        if (word_end) begin
                            bit_cnt <= '0;
                            M_VALID <= 1'b1;
                            M_DATA  <= word_next;
                            M_LAST  <= is_last;
                            if (!is_last)
                                word_cnt <= word_cnt + WORD_ONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_CRC: begin
                        for (int unsigned n = 0; n < 8; n++) begin
                            if (lane_mask[n] && (i_rx_data[n] != crc[n][NCRC-1]))
                                crc_err <= 1'b1;
                            crc[n] <= {crc[n][NCRC-2:0], 1'b0};
                        end
                        bit_cnt <= crc_end ? '0 : bit_cnt + 1'b1;
                    end
                    S_STOP: begin
                        o_done <= 1'b1;
                        o_err  <= crc_err | (lane_bits != lane_mask);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdrxframe.sv
// Testbench for sdrxframe: randomized frames checked through a scoreboard
// against a reference model computing per-lane CRCs by polynomial division.
module tb_sdrxframe;

    localparam int          NCRC  = 16;
    localparam logic [15:0] POLY  = 16'h1021;
    localparam int          LGLEN = 12;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [1:0]       i_cfg_width;
    logic             i_en;
    logic [LGLEN-1:0] i_length;
    logic             i_rx_strb;
    logic [7:0]       i_rx_data;
    logic             M_VALID;
    logic [31:0]      M_DATA;
    logic             M_LAST;
    logic             o_done;
    logic             o_err;
    logic             o_active;

    always #5 i_clk = ~i_clk;

    sdrxframe #(
        .NCRC(NCRC),
        .CRC_POLYNOMIAL(POLY),
        .LGLEN(LGLEN)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cfg_width(i_cfg_width),
        .i_en(i_en),
        .i_length(i_length),
        .i_rx_strb(i_rx_strb),
        .i_rx_data(i_rx_data),
        .M_VALID(M_VALID),
        .M_DATA(M_DATA),
        .M_LAST(M_LAST),
        .o_done(o_done),
        .o_err(o_err),
        .o_active(o_active)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } wexp_t;

    wexp_t       wq[$];
    bit          dq[$];
    logic [31:0] fw[$];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic void chk(input string name, input bit ok,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Remainder of (message * x^16) mod P by long division of the augmented message.
    function automatic logic [15:0] crc_div(input bit q[$]);
        logic [16:0] rem;
        rem = '0;
        for (int i = 0; i < q.size() + 16; i++) begin
            rem = {rem[15:0], (i < q.size()) ? q[i] : 1'b0};
            if (rem[16])
                rem[15:0] = rem[15:0] ^ POLY;
        end
        return rem[15:0];
    endfunction

    // Scoreboard monitor
    always @(negedge i_clk) begin
        wexp_t e;
        bit    de;
        if (M_VALID) begin
            if (wq.size() == 0) begin
                chk("unexpected_word", 1'b0, M_DATA, 32'h0);
            end else begin
                e = wq.pop_front();
                chk("word_data", M_DATA === e.d, M_DATA, e.d);
                chk("word_last", M_LAST === e.l, {31'h0, M_LAST}, {31'h0, e.l});
            end
        end
        if (o_done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1'b0, {31'h0, o_err}, 32'h0);
            end else begin
                de = dq.pop_front();
                chk("done_err", o_err === de, {31'h0, o_err}, {31'h0, de});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d, input bit en_v);
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                i_rx_strb = 1'b0;
                i_rx_data = 8'($urandom);
                tick();
            end
        end
        i_en      = en_v;
        i_rx_strb = 1'b1;
        i_rx_data = d;
        tick();
        i_rx_strb = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    function automatic int lanes_of(input int wsel);
        return (wsel == 0) ? 1 : (wsel == 1) ? 4 : 8;
    endfunction

    // Sends fw[] as one frame. flip_lane >= 0 corrupts one CRC bit on that lane;
    // abort_words >= 0 drops i_en on the completing strobe of the next word.
    task automatic run_frame(input int wsel, input int flip_lane,
                             input bit end_ok, input int abort_words);
        int          w;
        int          flip_idx;
        bit          bits[$];
        bit          lq[$];
        logic [15:0] crc[8];
        logic [7:0]  mask;
        logic [7:0]  d;
        int          nstr;
        w    = lanes_of(wsel);
        mask = (w == 1) ? 8'h01 : (w == 4) ? 8'h0F : 8'hFF;
        for (int i = 0; i < fw.size(); i++) begin
            if (abort_words < 0 || i < abort_words)
                wq.push_back({fw[i], (abort_words < 0) && (i == fw.size() - 1)});
            for (int b = 31; b >= 0; b--)
                bits.push_back(fw[i][b]);
        end
        for (int n = 0; n < 8; n++) begin
            lq.delete();
            if (n < w)
                for (int p = w - 1 - n; p < bits.size(); p += w)
                    lq.push_back(bits[p]);
            crc[n] = crc_div(lq);
        end
        if (abort_words < 0)
            dq.push_back(((flip_lane >= 0) && (flip_lane < w)) || !end_ok);

        i_cfg_width = 2'(wsel);
        i_length    = LGLEN'(fw.size() * 4);
        i_en        = 1'b1;
        tick();
        i_cfg_width = 2'($urandom);
        i_length    = LGLEN'($urandom);
        chk("active_after_arm", o_active === 1'b1, {31'h0, o_active}, 32'h1);

        repeat ($urandom_range(0, 3)) begin
            d = 8'($urandom) | (8'h01 << $urandom_range(0, w - 1));
            strobe(d, 1'b1);
        end
        strobe(8'($urandom) & ~mask, 1'b1);

        nstr = bits.size() / w;
        for (int s = 0; s < nstr; s++) begin
            d = 8'($urandom);
            for (int j = 0; j < w; j++)
                d[w-1-j] = bits[s*w + j];
            if (abort_words >= 0 && s == (abort_words + 1) * (32 / w) - 1) begin
                strobe(d, 1'b0);
                @(negedge i_clk);
                chk("active_after_abort", o_active === 1'b0, {31'h0, o_active}, 32'h0);
                tick();
                tick();
                return;
            end
            strobe(d, 1'b1);
        end

        flip_idx = $urandom_range(0, NCRC - 1);
        for (int k = 0; k < NCRC; k++) begin
            d = 8'($urandom);
            for (int n = 0; n < w; n++) begin
                d[n] = crc[n][NCRC-1-k];
                if (n == flip_lane && k == flip_idx)
                    d[n] = ~d[n];
            end
            strobe(d, 1'b1);
        end

        if (end_ok)
            d = 8'($urandom) | mask;
        else
            d = (8'($urandom) | mask) & ~(8'h01 << $urandom_range(0, w - 1));
        strobe(d, 1'b1);
        i_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic reset_mid_word();
        i_cfg_width = 2'b00;
        i_length    = LGLEN'(4);
        i_en        = 1'b1;
        tick();
        strobe(8'h00, 1'b1);
        repeat (10) strobe(8'($urandom), 1'b1);
        i_reset   = 1'b1;
        i_rx_strb = 1'b1;
        i_rx_data = 8'($urandom);
        tick();
        @(negedge i_clk);
        chk("rst_mid_flags", {M_VALID, M_LAST, o_done, o_err, o_active} === 5'b0,
            {27'h0, M_VALID, M_LAST, o_done, o_err, o_active}, 32'h0);
        chk("rst_mid_data", M_DATA === 32'h0, M_DATA, 32'h0);
        i_reset   = 1'b0;
        i_en      = 1'b0;
        i_rx_strb = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int nw;
        int wsel;
        int fl;
        i_reset     = 1'b1;
        i_cfg_width = 2'b00;
        i_en        = 1'b0;
        i_length    = '0;
        i_rx_strb   = 1'b0;
        i_rx_data   = 8'h00;
        repeat (3) tick();
        @(negedge i_clk);
        chk("reset_flags", {M_VALID, M_LAST, o_done, o_err, o_active} === 5'b0,
            {27'h0, M_VALID, M_LAST, o_done, o_err, o_active}, 32'h0);
        chk("reset_data", M_DATA === 32'h0, M_DATA, 32'h0);
        i_reset = 1'b0;
        tick();

        // Single word, 1 lane, clean
        fw.delete();
        fw.push_back(32'hA5A55A5A);
        run_frame(0, -1, 1'b1, -1);

        // 512-byte block of incrementing bytes, 4 lanes
        fw.delete();
        for (int i = 0; i < 128; i++)
            fw.push_back({8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
        run_frame(1, -1, 1'b1, -1);

        // 8 lanes, corrupted CRC bit on lane 5
        fw.delete();
        repeat (2) fw.push_back($urandom);
        run_frame(3, 5, 1'b1, -1);

        // 1 lane, bad end bit
        fw.delete();
        fw.push_back($urandom);
        run_frame(0, -1, 1'b0, -1);

        // Abort after three words, then a clean re-armed frame
        fw.delete();
        repeat (4) fw.push_back($urandom);
        run_frame(1, -1, 1'b1, 3);
        fw.delete();
        repeat (4) fw.push_back($urandom);
        run_frame(1, -1, 1'b1, -1);

        reset_mid_word();

        // Random frames; flips on inactive lanes must not raise errors
        repeat (10) begin
            fw.delete();
            nw = $urandom_range(1, 5);
            repeat (nw) fw.push_back($urandom);
            wsel = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            run_frame(wsel, fl, $urandom_range(0, 3) != 0, -1);
        end

        for (int c = 0; c < 200 && (wq.size() != 0 || dq.size() != 0); c++)
            tick();
        chk("words_drained", wq.size() == 0, 32'(wq.size()), 32'h0);
        chk("dones_drained", dq.size() == 0, 32'(dq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdrxframe.md
SDRXFRAME -- requirements
Module: sdrxframe

Interface
REQ-001 SHALL have parameter NCRC, default 16, CRC width per lane.
REQ-002 SHALL have parameter CRC_POLYNOMIAL, default 16'h1021, per-lane CRC polynomial.
REQ-003 SHALL have parameter LGLEN, default 12, width of the byte-length input.
REQ-004 SHALL have i_clk, input, 1, the one clock; all logic on its rising edge.
REQ-005 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have i_cfg_width, input, 2: 2'b00 = 1 lane, 2'b01 = 4 lanes, 2'b1x = 8 lanes.
REQ-007 SHALL have i_en, input, 1: arm/hold receive; low aborts.
REQ-008 SHALL have i_length, input, LGLEN: block byte count, multiple of 4, nonzero.
REQ-009 SHALL have i_rx_strb, input, 1: one DAT sample valid this cycle.
REQ-010 SHALL have i_rx_data, input, 8: DAT[7:0] sample; DAT0 = bit 0.
REQ-011 SHALL have M_VALID, output, 1: received word valid (one-cycle pulse, no backpressure).
REQ-012 SHALL have M_DATA, output, 32: received word, first-received bits in MSBs.
REQ-013 SHALL have M_LAST, output, 1: qualifies final word of block.
REQ-014 SHALL have o_done, output, 1: one-cycle pulse at frame completion.
REQ-015 SHALL have o_err, output, 1: CRC or end-bit error; valid with o_done, held until next arm.
REQ-016 SHALL have o_active, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL latch i_cfg_width and i_length only in IDLE; both are ignored mid-frame.
REQ-018 SHALL implement states IDLE, START, DATA, CRC, STOP.
REQ-019 IDLE->START when i_en=1, clearing o_err, word and bit counters, and all lane CRCs to zero.
REQ-020 START->DATA on the first strobe where every active lane reads 0; strobes with any active lane 1 are ignored.
REQ-021 In DATA, each strobe SHALL shift W bits (W=1/4/8) MSB-first into the word register: 1W takes DAT0; 4W takes DAT[3:0] with DAT3 as the MSB of the nibble; 8W takes DAT[7:0].
REQ-022 After 32/W strobes, the completed word SHALL appear on M_DATA with M_VALID=1 on the cycle after the completing strobe.
REQ-023 M_LAST SHALL be 1 on the word numbered i_length/4; DATA->CRC on that word's completing strobe.
REQ-024 Each lane n SHALL run an independent serial CRC over its own bits: each bit shifts into the register, and CRC_POLYNOMIAL is XORed in when (msb XOR bit) is 1.
REQ-025 CRC SHALL consume NCRC strobes, comparing each lane's received bit MSB-first against its computed CRC; any mismatch sets a sticky crc_err.
REQ-026 CRC->STOP after NCRC strobes; the STOP strobe requires all active lanes = 1, otherwise o_err is set.
REQ-027 On the STOP strobe SHALL go to IDLE, pulse o_done the next cycle, and set o_err = crc_err OR end-bit error.
REQ-028 Inactive lanes SHALL be ignored for all checks.
REQ-029 When i_rx_strb=0, no state, counter, or CRC SHALL change.
REQ-030 i_en=0 in any non-IDLE state SHALL return the block to IDLE next cycle with no o_done and no further M_VALID; a word completing in that same cycle SHALL be discarded.
REQ-031 The word counter SHALL be LGLEN-2 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-032 i_reset SHALL force IDLE with M_VALID=0, M_DATA=0, M_LAST=0, o_done=0, o_err=0, o_active=0, counters=0, and CRCs=0.
REQ-033 Reset SHALL take priority over all other inputs including i_rx_strb, and mid-frame SHALL discard the partial word silently.

Verification
REQ-034 1W, i_length=4, bits of 32'hA5A55A5A followed by its correct CRC16 and end bit 1 -> one M_VALID with M_DATA=32'hA5A55A5A and M_LAST=1; then o_done=1 with o_err=0.
REQ-035 4W, i_length=512, incrementing bytes, correct per-lane CRCs -> 128 M_VALID pulses, M_LAST only on the 128th, o_err=0.
REQ-036 8W, i_length=8, one lane-5 CRC bit flipped -> 2 words delivered, o_done=1 with o_err=1.
REQ-037 1W, correct data and CRC, end bit 0 -> o_done=1 with o_err=1.
REQ-038 4W, i_en dropped after 3 words of a 16-byte block -> o_active=0 next cycle, no 4th M_VALID, no o_done; a re-armed frame then passes cleanly.
REQ-039 i_reset asserted mid-word with i_rx_strb=1 -> all outputs 0 next cycle, no M_VALID emitted.
